// File: rtl/i2s_rx_deserializer.sv
// I2S receive deserializer.
// Oversamples sclk/ws/sd with the system clock, finds sclk rising edges and
// assembles MSB-first channel words. A left/right pair is flagged with a
// one-clk sample_valid pulse; slots that end early raise a one-clk frame_err.
//
// Pipeline from a raw sclk rising edge:
//   clk 1: first synchronizer stage
//   clk 2: second synchronizer stage (sclk_s high)
//   clk 3: rise strobe registered together with the ws/sd samples
//   clk 4: word committed to left_data/right_data (and sample_valid)
// ws and sd change on the falling sclk edge, at least half an sclk period
// before the next rise. Their synchronized copies are therefore settled when
// the strobe samples them.

module i2s_rx_deserializer #(
  parameter int unsigned DATA_WIDTH    = 24,
  parameter int unsigned MIN_SCLK_CLKS = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sclk_in,
  input  logic                  ws_in,
  input  logic                  sd_in,
  output logic [DATA_WIDTH-1:0] left_data,
  output logic [DATA_WIDTH-1:0] right_data,
  output logic                  sample_valid,
  output logic                  frame_err
);

  // Fewer than two clk per sclk phase would let ws/sd still be in flight
  // through the synchronizers when the rise strobe samples them.
  if (MIN_SCLK_CLKS < 4) begin : g_min_sclk_check
    $error("MIN_SCLK_CLKS must be at least 4");
  end

  localparam int unsigned CntW = $clog2(DATA_WIDTH + 1);
  localparam logic [CntW-1:0] LastIdx = CntW'(DATA_WIDTH - 1);
  localparam logic [CntW-1:0] SatCnt  = CntW'(DATA_WIDTH);

  typedef enum logic [1:0] {
    StSync,
    StCapture,
    StDrain
  } state_t;

  // Synchronizer stages, bit order {sclk, ws, sd}
  logic [2:0] meta_q;
  logic [2:0] sync_q;
  logic       sclk_s;
  logic       ws_s;
  logic       sd_s;

  // Rise strobe and the ws/sd values sampled with it
  logic       sclk_prev_q;
  logic       rise_q;
  logic       ws_smp_q;
  logic       sd_smp_q;

  // Slot tracking
  state_t              state_q;
  logic [CntW-1:0]     bit_cnt_q;
  logic                slot_ch_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                ws_prev_q;
  logic                left_pending_q;

  // Decoded events
  logic                  boundary;
  logic [DATA_WIDTH-1:0] word;
  logic                  commit;
  logic                  short_slot;

  assign {sclk_s, ws_s, sd_s} = sync_q;

  // Two-flop synchronizers for the three asynchronous I2S pins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= {sclk_in, ws_in, sd_in};
      sync_q <= meta_q;
    end
  end

  // Single-clk rise strobe; ws/sd are captured in the same cycle as the strobe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_prev_q <= 1'b0;
      rise_q      <= 1'b0;
      ws_smp_q    <= 1'b0;
      sd_smp_q    <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      rise_q      <= sclk_s & ~sclk_prev_q;
      ws_smp_q    <= ws_s;
      sd_smp_q    <= sd_s;
    end
  end

  // Event decode. The sd bit at a boundary rise still belongs to the slot that
  // is ending, so a slot with exactly DATA_WIDTH rises completes its word on
  // the boundary rise itself.
  always_comb begin
    boundary   = rise_q && (ws_smp_q != ws_prev_q);
    word       = {shift_q[DATA_WIDTH-2:0], sd_smp_q};
    commit     = rise_q && (state_q == StCapture) && (bit_cnt_q == LastIdx);
    short_slot = boundary && (state_q == StCapture) && (bit_cnt_q != LastIdx);
  end

  // Slot state machine: wait for a boundary, capture DATA_WIDTH bits, then
  // drain the rest of the slot until the next boundary.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StSync;
      bit_cnt_q <= '0;
      slot_ch_q <= 1'b0;
      shift_q   <= '0;
      ws_prev_q <= 1'b0;
    end else if (rise_q) begin
      ws_prev_q <= ws_smp_q;
      if (boundary) begin
        // Any boundary starts a fresh slot for the channel now on ws.
        state_q   <= StCapture;
        bit_cnt_q <= '0;
        slot_ch_q <= ws_smp_q;
        shift_q   <= '0;
      end else begin
        case (state_q)
          StSync: begin
            state_q <= StSync;
          end
          StCapture: begin
            shift_q <= word;
            if (bit_cnt_q == LastIdx) begin
              bit_cnt_q <= SatCnt;
              state_q   <= StDrain;
            end else begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end
          StDrain: begin
            // Extra slot bits are ignored; the counter stays saturated.
            bit_cnt_q <= SatCnt;
          end
          default: begin
            state_q <= StSync;
          end
        endcase
      end
    end
  end

  // Output registers: commit words, pair tracking and one-clk pulses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      left_data      <= '0;
      right_data     <= '0;
      sample_valid   <= 1'b0;
      frame_err      <= 1'b0;
      left_pending_q <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      frame_err    <= short_slot;
      if (commit) begin
        if (!slot_ch_q) begin
          left_data      <= word;
          left_pending_q <= 1'b1;
        end else begin
          right_data <= word;
          if (left_pending_q) begin
            sample_valid   <= 1'b1;
            left_pending_q <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
// Bench for i2s_rx_deserializer: drives I2S frames described as a list of
// slots (channel, width in sclks, word) and compares the DUT against a slot
// level model of what should be committed.

module tb_i2s_rx_deserializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        sclk;
  logic        ws;
  logic        sd;
  logic [23:0] left24;
  logic [23:0] right24;
  logic        sv24;
  logic        fe24;
  logic [15:0] left16;
  logic [15:0] right16;
  logic        sv16;
  logic        fe16;

  i2s_rx_deserializer dut24 (
    .clk          (clk),
    .reset_n      (reset_n),
    .sclk_in      (sclk),
    .ws_in        (ws),
    .sd_in        (sd),
    .left_data    (left24),
    .right_data   (right24),
    .sample_valid (sv24),
    .frame_err    (fe24)
  );

  i2s_rx_deserializer #(
    .DATA_WIDTH (16)
  ) dut16 (
    .clk          (clk),
    .reset_n      (reset_n),
    .sclk_in      (sclk),
    .ws_in        (ws),
    .sd_in        (sd),
    .left_data    (left16),
    .right_data   (right16),
    .sample_valid (sv16),
    .frame_err    (fe16)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  // Observations
  logic [23:0] obs24_l[$];
  logic [23:0] obs24_r[$];
  int          obs24_cyc[$];
  logic [23:0] obs16_l[$];
  logic [23:0] obs16_r[$];
  int          err24 = 0;
  int          err16 = 0;

  // Stimulus description and expanded per-sclk stream
  bit          s_ch[$];
  int          s_n[$];
  logic [23:0] s_word[$];
  bit          ws_q[$];
  bit          sd_q[$];
  int          rise_cyc[$];

  // Expectations
  logic [23:0] exp_l[$];
  logic [23:0] exp_r[$];
  int          exp_err;
  logic [23:0] exp_last_l;
  logic [23:0] exp_last_r;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (sv24 === 1'b1) begin
      obs24_l.push_back(left24);
      obs24_r.push_back(right24);
      obs24_cyc.push_back(cyc);
    end
    if (fe24 === 1'b1) err24++;
    if (sv16 === 1'b1) begin
      obs16_l.push_back({8'h00, left16});
      obs16_r.push_back({8'h00, right16});
    end
    if (fe16 === 1'b1) err16++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_obs();
    obs24_l.delete();
    obs24_r.delete();
    obs24_cyc.delete();
    obs16_l.delete();
    obs16_r.delete();
    err24 = 0;
    err16 = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    sclk    = 1'b0;
    ws      = 1'b0;
    sd      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_obs();
  endtask

  task automatic clear_slots();
    s_ch.delete();
    s_n.delete();
    s_word.delete();
  endtask

  task automatic add_slot(input bit ch, input int n, input logic [23:0] word);
    s_ch.push_back(ch);
    s_n.push_back(n);
    s_word.push_back(word);
  endtask

  // Expand slots into per-sclk ws/sd values. Each word is sent MSB first from
  // the start of its slot, then the whole data stream is delayed by one sclk
  // (I2S). A short trailing slot supplies the last boundary.
  task automatic build(input int w);
    bit raw[$];
    logic [23:0] wd;
    bit last_ch;
    ws_q.delete();
    sd_q.delete();
    rise_cyc.delete();
    last_ch = 1'b0;
    for (int j = 0; j < s_n.size(); j++) begin
      wd = s_word[j];
      for (int i = 0; i < s_n[j]; i++) begin
        ws_q.push_back(s_ch[j]);
        raw.push_back((i < w) ? wd[w-1-i] : 1'b0);
      end
      last_ch = s_ch[j];
    end
    for (int i = 0; i < 3; i++) begin
      ws_q.push_back(!last_ch);
      raw.push_back(1'b0);
    end
    sd_q.push_back(1'b0);
    for (int k = 0; k < raw.size() - 1; k++) sd_q.push_back(raw[k]);
  endtask

  // Slot level reference: a slot counts only after the first ws change seen
  // since reset; a slot of at least w sclks yields its word, a shorter one an
  // error; a right word completes a pair only if a left word preceded it.
  task automatic model(input int w);
    bit pend;
    bit started;
    logic [23:0] wm;
    pend    = 1'b0;
    started = 1'b0;
    exp_l.delete();
    exp_r.delete();
    exp_err    = 0;
    exp_last_l = '0;
    exp_last_r = '0;
    for (int j = 0; j < s_n.size(); j++) begin
      wm = (w == 16) ? {8'h00, s_word[j][15:0]} : s_word[j];
      if (!started && !s_ch[j]) continue;
      started = 1'b1;
      if (s_n[j] < w) begin
        exp_err++;
      end else if (!s_ch[j]) begin
        exp_last_l = wm;
        pend       = 1'b1;
      end else begin
        exp_last_r = wm;
        if (pend) begin
          exp_l.push_back(exp_last_l);
          exp_r.push_back(wm);
          pend = 1'b0;
        end
      end
    end
  endtask

  // Play stream entries [0, stop) with an sclk period of p clk; ws/sd change
  // with the falling sclk edge.
  task automatic play(input int p, input int stop);
    for (int k = 0; k < stop; k++) begin
      @(posedge clk);
      #1;
      sclk = 1'b0;
      ws   = ws_q[k];
      sd   = sd_q[k];
      repeat (p / 2 - 1) @(posedge clk);
      @(posedge clk);
      #1;
      sclk = 1'b1;
      rise_cyc.push_back(cyc);
      repeat (p - p / 2 - 1) @(posedge clk);
    end
  endtask

  task automatic check_phase(input string tag, input int w);
    logic [23:0] ol[$];
    logic [23:0] orr[$];
    int oe;
    logic [23:0] fl;
    logic [23:0] fr;
    if (w == 16) begin
      ol  = obs16_l;
      orr = obs16_r;
      oe  = err16;
      fl  = {8'h00, left16};
      fr  = {8'h00, right16};
    end else begin
      ol  = obs24_l;
      orr = obs24_r;
      oe  = err24;
      fl  = left24;
      fr  = right24;
    end
    check($sformatf("%s sample_valid count", tag), ol.size(), exp_l.size());
    for (int i = 0; i < exp_l.size(); i++) begin
      if (i < ol.size()) begin
        check($sformatf("%s pair%0d left", tag, i), 32'(ol[i]), 32'(exp_l[i]));
        check($sformatf("%s pair%0d right", tag, i), 32'(orr[i]), 32'(exp_r[i]));
      end
    end
    check($sformatf("%s frame_err count", tag), oe, exp_err);
    check($sformatf("%s final left_data", tag), 32'(fl), 32'(exp_last_l));
    check($sformatf("%s final right_data", tag), 32'(fr), 32'(exp_last_r));
  endtask

  task automatic run_phase(input string tag, input int w, input int p);
    build(w);
    model(w);
    play(p, ws_q.size());
    repeat (8) @(posedge clk);
    #1;
    check_phase(tag, w);
  endtask

  initial begin
    int lat;
    reset_n = 1'b0;
    sclk    = 1'b0;
    ws      = 1'b0;
    sd      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset left_data", 32'(left24), 32'h0);
    check("reset right_data", 32'(right24), 32'h0);
    check("reset sample_valid", 32'(sv24), 32'h0);
    check("reset frame_err", 32'(fe24), 32'h0);
    check("reset left_data w16", 32'(left16), 32'h0);
    check("reset right_data w16", 32'(right16), 32'h0);

    // Nominal 64-sclk frames with fixed then random words
    do_reset();
    clear_slots();
    add_slot(1'b1, 32, 24'($urandom()));
    for (int f = 0; f < 3; f++) begin
      add_slot(1'b0, 32, 24'hA5A5A5);
      add_slot(1'b1, 32, 24'h5A5A5A);
    end
    for (int f = 0; f < 2; f++) begin
      add_slot(1'b0, 32, 24'($urandom()));
      add_slot(1'b1, 32, 24'($urandom()));
    end
    run_phase("nominal", 24, 6);

    // One left slot cut to 16 sclks
    do_reset();
    clear_slots();
    add_slot(1'b1, 32, 24'($urandom()));
    add_slot(1'b0, 32, 24'($urandom()));
    add_slot(1'b1, 32, 24'($urandom()));
    add_slot(1'b0, 16, 24'($urandom()));
    add_slot(1'b1, 32, 24'($urandom()));
    add_slot(1'b0, 32, 24'($urandom()));
    add_slot(1'b1, 32, 24'($urandom()));
    run_phase("short_left", 24, 4);

    // Reset released in the middle of a right slot
    do_reset();
    clear_slots();
    add_slot(1'b1, 10, 24'($urandom()));
    add_slot(1'b0, 32, 24'($urandom()));
    add_slot(1'b1, 32, 24'($urandom()));
    add_slot(1'b0, 32, 24'($urandom()));
    add_slot(1'b1, 32, 24'($urandom()));
    run_phase("mid_slot_release", 24, 4);

    // Reset pulsed for 3 clk while a left word is being captured
    do_reset();
    clear_slots();
    add_slot(1'b1, 32, 24'($urandom()));
    add_slot(1'b0, 32, 24'hC3C3C3);
    add_slot(1'b1, 32, 24'($urandom()));
    add_slot(1'b0, 32, 24'($urandom()));
    build(24);
    play(6, 32 * 3 + 10);
    @(posedge clk);
    #1;
    check("pre-reset left_data", 32'(left24), 32'hC3C3C3);
    reset_n = 1'b0;
    #2;
    check("async reset left_data", 32'(left24), 32'h0);
    check("async reset right_data", 32'(right24), 32'h0);
    check("async reset sample_valid", 32'(sv24), 32'h0);
    check("async reset frame_err", 32'(fe24), 32'h0);
    repeat (3) @(posedge clk);
    #1;
    sclk    = 1'b0;
    ws      = 1'b0;
    sd      = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear_obs();
    clear_slots();
    add_slot(1'b1, 32, 24'($urandom()));
    add_slot(1'b0, 32, 24'($urandom()));
    add_slot(1'b1, 32, 24'($urandom()));
    run_phase("after_reset_pulse", 24, 6);

    // Minimum sclk period, 48-sclk frames, latency of the right commit
    do_reset();
    clear_slots();
    add_slot(1'b1, 24, 24'($urandom()));
    add_slot(1'b0, 24, 24'h000001);
    add_slot(1'b1, 24, 24'h800000);
    add_slot(1'b0, 24, 24'($urandom()));
    add_slot(1'b1, 24, 24'($urandom()));
    run_phase("min_period", 24, 4);
    // Last bit of the 24'h800000 word rides the boundary rise at index 72
    lat = (obs24_cyc.size() > 0) ? (obs24_cyc[0] - rise_cyc[72]) : -1;
    check("min_period commit latency", lat, 4);

    // 16-bit instance: 32-sclk frames, then wider slots with ignored bits
    do_reset();
    clear_slots();
    add_slot(1'b1, 16, 24'($urandom()));
    add_slot(1'b0, 16, 24'h00BEEF);
    add_slot(1'b1, 16, 24'h001234);
    add_slot(1'b0, 20, 24'($urandom()));
    add_slot(1'b1, 20, 24'($urandom()));
    add_slot(1'b0, 16, 24'($urandom()));
    add_slot(1'b1, 16, 24'($urandom()));
    run_phase("width16", 16, 4);

    // Random slot widths (some short) and sclk period
    do_reset();
    clear_slots();
    add_slot(1'b1, 32, 24'($urandom()));
    for (int j = 0; j < 10; j++) begin
      add_slot(j[0] ? 1'b1 : 1'b0, int'($urandom_range(20, 40)), 24'($urandom()));
    end
    run_phase("random", 24, int'($urandom_range(4, 8)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
